// File: rtl/alu_if.sv
// Bus-side signal bundle for the accumulator ALU.
// Status flags Z/N/C/V exist only when ALU_STATUS_FLAGS_EN is defined.
interface alu_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] bus;
  logic             A_ena;
  logic             Add_SubNot;
  logic             G_ena;
  logic [WIDTH-1:0] ALUout;
`ifdef ALU_STATUS_FLAGS_EN
  logic             Z;
  logic             N;
  logic             C;
  logic             V;
`endif

`ifdef ALU_STATUS_FLAGS_EN
  modport master (
    output bus, A_ena, Add_SubNot, G_ena,
    input  ALUout, Z, N, C, V
  );
  modport slave (
    input  bus, A_ena, Add_SubNot, G_ena,
    output ALUout, Z, N, C, V
  );
`else
  modport master (
    output bus, A_ena, Add_SubNot, G_ena,
    input  ALUout
  );
  modport slave (
    input  bus, A_ena, Add_SubNot, G_ena,
    output ALUout
  );
`endif
endinterface

// File: rtl/alu.sv
// Accumulator add/subtract unit: A <= bus, G <= A +/- bus, ALUout = G.
// Optional registered Z/N/C/V flags under macro ALU_STATUS_FLAGS_EN.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  io
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;

  // Subtract is A + ~bus + 1; the extra bit holds the carry / no-borrow.
  always_comb begin
    w_b   = io.Add_SubNot ? io.bus : ~io.bus;
    w_sum = {1'b0, r_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, ~io.Add_SubNot};
  end

  // Operand and result registers; G sees the pre-edge A when both enables fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= {WIDTH{1'b0}};
      r_g <= {WIDTH{1'b0}};
    end else begin
      if (io.A_ena) begin
        r_a <= io.bus;
      end
      if (io.G_ena) begin
        r_g <= w_sum[WIDTH-1:0];
      end
    end
  end

  assign io.ALUout = r_g;

`ifdef ALU_STATUS_FLAGS_EN
  logic r_z;
  logic r_n;
  logic r_c;
  logic r_v;

  // Flags track the value loaded into G and only change on G loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z <= 1'b0;
      r_n <= 1'b0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else if (io.G_ena) begin
      r_z <= (w_sum[WIDTH-1:0] == {WIDTH{1'b0}});
      r_n <= w_sum[WIDTH-1];
      r_c <= w_sum[WIDTH];
      r_v <= (r_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    end
  end

  assign io.Z = r_z;
  assign io.N = r_n;
  assign io.C = r_c;
  assign io.V = r_v;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected G/flags, a negedge monitor pops and compares.
module tb_alu;

  logic clk;
  logic rst;

  alu_if #(.WIDTH(16)) u_if ();

  alu #(.WIDTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .io  (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] g;
    logic [3:0]  f;   // {Z, N, C, V}
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Drive one edge worth of controls; queue the expected post-edge state if requested.
  task automatic step(input logic r, input logic a_en, input logic g_en, input logic add,
                      input logic [15:0] b, input bit chk, input logic [15:0] eg,
                      input logic [3:0] ef, input string nm);
    exp_t e;
    @(negedge clk);
    rst             = r;
    u_if.A_ena      = a_en;
    u_if.G_ena      = g_en;
    u_if.Add_SubNot = add;
    u_if.bus        = b;
    @(posedge clk);
    #1;
    if (chk) begin
      e.g  = eg;
      e.f  = ef;
      e.nm = nm;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      m_e = sb_q.pop_front();
      n_checks++;
      if (u_if.ALUout !== m_e.g) begin
        n_errors++;
        $display("FAIL %s: ALUout=0x%04h expected 0x%04h", m_e.nm, u_if.ALUout, m_e.g);
      end
`ifdef ALU_STATUS_FLAGS_EN
      n_checks++;
      if ({u_if.Z, u_if.N, u_if.C, u_if.V} !== m_e.f) begin
        n_errors++;
        $display("FAIL %s_flags: ZNCV=%b expected %b", m_e.nm,
                 {u_if.Z, u_if.N, u_if.C, u_if.V}, m_e.f);
      end
`endif
    end
  end

  initial begin
    rst             = 1'b1;
    u_if.A_ena      = 1'b0;
    u_if.G_ena      = 1'b0;
    u_if.Add_SubNot = 1'b0;
    u_if.bus        = 16'h0000;

    //    rst   A_ena G_ena add   bus       chk   G         ZNCV      name
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 4'b0000, "reset_init");
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, 4'b0000, "");
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, 16'h2345, 4'b0000, "pre_reset_add");
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, 1'b1, 16'h0000, 4'b0000, "reset_after_loads");
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, 4'b1000, "reset_clears_a");

    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0F00, 1'b0, 16'h0000, 4'b0000, "");
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h000F, 1'b1, 16'h0EF1, 4'b0010, "sub_0f00_000f");
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b1, 16'h0EF1, 4'b0010, "hold_g_idle");
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h00F0, 1'b1, 16'h0EF1, 4'b0010, "hold_g_on_a_load");
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h000F, 1'b1, 16'h00FF, 4'b0000, "add_00f0_000f");

    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 4'b0000, "");
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0000, 4'b1010, "wrap_add");
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b0000, "");
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, 16'hFFFF, 4'b0100, "wrap_sub");

    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 1'b0, 16'h0000, 4'b0000, "");
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b1, 16'h0015, 4'b0000, "simul_old_a");
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0006, 4'b0000, "simul_new_a");

    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0042, 1'b0, 16'h0000, 4'b0000, "");
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0000, 4'b0000, "reset_beats_g_ena");
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b1, 16'hFFFD, 4'b0100, "sub_after_reset");

    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b0, 16'h0000, 4'b0000, "");
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h8000, 4'b0101, "ovf_add");
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b0, 16'h0000, 4'b0000, "");
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, 16'h7FFF, 4'b0011, "ovf_sub");

    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 16'h0000, 4'b0000, "");
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0006, 4'b0000, "held_g_add");
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 16'h0003, 4'b0010, "held_g_sub");

    @(negedge clk);
    u_if.A_ena = 1'b0;
    u_if.G_ena = 1'b0;

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
